// File: rtl/logic_issue.sv
// logic_issue: two-stage issue/retire wrapper around a 32-bit bitwise logic unit for MIPS32 logical ops.
// Optional NOR support (inverted OR result) is enabled by defining LOGIC_ISSUE_NOR_EN.
module logic_issue #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [5:0]       in_funct,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  input  logic [15:0]      in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      lu_a,
  output logic [31:0]      lu_b,
  output logic [3:0]       lu_c,
  input  logic [31:0]      lu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  logic             s1_valid_q;
  logic [31:0]      s1_a_q, s1_b_q;
  logic [3:0]       s1_c_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_err_q;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_err_q;
  logic [31:0]      dec_a, dec_b, res_d;
  logic [3:0]       dec_c;
  logic             dec_err, s1_adv, s2_adv;
`ifdef LOGIC_ISSUE_NOR_EN
  logic             dec_inv, s1_inv_q;
`endif

  // Every supported op yields a non-zero one-hot code, so a zero code marks an illegal instruction.
  always_comb begin
    dec_c = 4'b0000;
`ifdef LOGIC_ISSUE_NOR_EN
    dec_inv = 1'b0;
`endif
    if (in_op == 6'h00) begin
      dec_c = in_funct == 6'h24 ? 4'b0010 : in_funct == 6'h25 ? 4'b0001 :
              in_funct == 6'h26 ? 4'b1000 : 4'b0000;
`ifdef LOGIC_ISSUE_NOR_EN
      dec_inv = in_funct == 6'h27;
      if (dec_inv) dec_c = 4'b0001;
`endif
    end else begin
      dec_c = in_op == 6'h0c ? 4'b0010 : in_op == 6'h0d ? 4'b0001 :
              in_op == 6'h0e ? 4'b1000 : 4'b0000;
    end
    dec_err = dec_c == 4'b0000;
    dec_a   = dec_err ? '0 : in_rs;
    dec_b   = dec_err ? '0 : in_op == 6'h00 ? in_rt : {16'h0, in_imm};
  end

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
`ifdef LOGIC_ISSUE_NOR_EN
  assign res_d = s1_err_q ? '0 : s1_inv_q ? ~lu_res : lu_res;
`else
  assign res_d = s1_err_q ? '0 : lu_res;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      s1_tag_q    <= '0;
      s1_err_q    <= 1'b0;
`ifdef LOGIC_ISSUE_NOR_EN
      s1_inv_q    <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q   <= dec_a;
          s1_b_q   <= dec_b;
          s1_c_q   <= dec_c;
          s1_tag_q <= in_tag;
          s1_err_q <= dec_err;
`ifdef LOGIC_ISSUE_NOR_EN
          s1_inv_q <= dec_inv;
`endif
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= res_d;
          out_tag_q  <= s1_tag_q;
          out_err_q  <= s1_err_q;
        end
      end
    end
  end

  assign lu_a      = s1_a_q;
  assign lu_b      = s1_b_q;
  assign lu_c      = s1_valid_q ? s1_c_q : 4'b0000;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;
endmodule

// File: doc/logic_issue.md
# logic_issue

Registered issue/retire stage that feeds the 32-bit bitwise logic unit and captures its result. Decodes MIPS32 logical instructions (AND, OR, XOR, NOR, ANDI, ORI, XORI) into the unit's one-hot control code and operands, then returns the result with its destination tag. Sits between decode/register-read and writeback. Uses a valid/ready handshake on both sides, has two-cycle latency and sustains one instruction per cycle.

## Interface
Parameters:
- TAG_W, 5, width of destination-register tag.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  6  MIPS opcode field.
- in_funct  in  6  MIPS funct field; used only when in_op = 6'h00.
- in_rs  in  32  rs register value.
- in_rt  in  32  rt register value.
- in_imm  in  16  immediate field.
- in_tag  in  TAG_W  destination register.
- lu_a  out  32  operand A to the logic unit.
- lu_b  out  32  operand B to the logic unit.
- lu_c  out  4  one-hot op code to the logic unit: 0001 OR, 0010 AND, 0100 XNOR, 1000 XOR. Any other code yields result 0.
- lu_res  in  32  combinational result from the logic unit.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_data  out  32  result.
- out_tag  out  TAG_W  destination register of the result.
- out_err  out  1  instruction was not a supported logical op.

## Operation
- Two register stages:
  - S1 (issue) holds the decoded code, operands, invert flag, tag and err. It drives lu_a, lu_b and lu_c.
  - S2 (retire) holds out_data, out_tag and out_err.
- Decode of in_op / in_funct:
  - op 00, funct 24: c=0010, a=rs, b=rt.
  - op 00, funct 25: c=0001, a=rs, b=rt.
  - op 00, funct 26: c=1000, a=rs, b=rt.
  - op 00, funct 27 (NOR): c=0001, a=rs, b=rt, inv=1. See Configuration.
  - op 0C (ANDI): c=0010, a=rs, b={16'h0,imm}.
  - op 0D (ORI): c=0001, a=rs, b={16'h0,imm}.
  - op 0E (XORI): c=1000, a=rs, b={16'h0,imm}.
  - Anything else: c=0000, err=1, a=b=0.
- S2 capture: out_data = inv ? ~lu_res : lu_res. out_tag and out_err are copied from S1.
- The decoder never emits XNOR (0100). The code is valid on the lu_c bus but is unused by this block.
- lu_c is forced to 0000 whenever S1 is empty. lu_a and lu_b hold their last values.
- Illegal instructions still flow through the pipeline and retire with out_err=1 and out_data=0.

## Timing
- Reset values:
  - S1 valid 0, S2 valid 0.
  - out_valid 0, out_data 0, out_tag 0, out_err 0.
  - lu_a 0, lu_b 0, lu_c 0000.
  - in_ready is 1 in the first cycle after rst deasserts.
- Advance conditions:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. This is combinational and has no dependence on in_valid.
- Accept: when in_valid & in_ready, S1 loads in the same edge.
- Move: when s1_valid & s2_adv, S2 loads from S1 + lu_res in the same edge.
- Latency: accepted at edge N, out_valid=1 after edge N+1.
- Throughput: one instruction per cycle while out_ready=1.
- Stall: out_valid & !out_ready holds S2 and, if S1 is full, also holds S1, with in_ready=0. S1 outputs stay stable while stalled.
- Simultaneous events:
  - When S2 retires and S1 moves into S2 in the same cycle, both happen on one edge and S1 can also refill on that edge.
  - When S1 is empty and nothing is accepted, S2 clears its valid after retiring.
- Reset mid-operation: all in-flight instructions are discarded with no output. Outputs return to their reset values on the next edge.

## Configuration
- LOGIC_ISSUE_NOR_EN:
  - Defined: funct 27 decodes as OR with inv=1, so out_data = ~(rs|rt) and out_err = 0.
  - Undefined: the inv path is absent and funct 27 is illegal (out_err=1, out_data=0).

## Test plan
- Reset, then ANDI with rs=32'hF0F0_1234, imm=16'hFF00, tag=3 -> after 2 cycles out_valid=1, out_data=32'h0000_1200, out_tag=3, out_err=0. While S1 is full, lu_c=0010.
- Back-to-back OR, XOR, AND with rs=32'hAAAA_5555, rt=32'h0F0F_0F0F and out_ready=1 -> out_data sequence 32'hAFAF_5F5F, 32'hA5A5_5A5A, 32'h0A0A_0505 on consecutive cycles, with in_ready held at 1.
- NOR with rs=32'h1234_0000, rt=32'h0000_00FF:
  - Macro defined -> out_data=32'hEDCB_FF00, out_err=0.
  - Macro undefined -> out_data=0, out_err=1.
- Hold out_ready=0 for 4 cycles with 3 instructions offered -> S2 and S1 fill and in_ready=0. out_data and lu_* are stable. After out_ready is released, all three retire in order with no loss or duplication.
- in_op=6'h23 (LW) -> out_err=1, out_data=0, lu_c=0000.
- Assert rst while 2 instructions are in flight -> out_valid=0 and outputs at reset values on the next edge, and no result is emitted afterwards.
